// File: rtl/line_fill_ctrl_pkg.sv
// line_fill_ctrl_pkg: shared display defaults, fill FSM encoding and line-buffer address helper
package line_fill_ctrl_pkg;
  localparam int H_ACTIVE_DEF = 480;
  localparam int V_ACTIVE_DEF = 272;
  localparam int PIX_W_DEF    = 24;
  localparam int X_W          = 9;
  localparam int LINE_W       = 10;
  localparam int ADDR_W       = 10;
  localparam int BANK_BIT     = 9;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FILL = 2'd2
  } state_e;
  function automatic logic [ADDR_W-1:0] buf_addr(input logic bank, input logic [X_W-1:0] x);
    logic [ADDR_W-1:0] a;
    a = {1'b0, x};
    a[BANK_BIT] = bank;
    return a;
  endfunction
endpackage

// File: rtl/line_fill_ctrl.sv
// line_fill_ctrl: ping-pong fill sequencer streaming source lines into the inactive half of a 1024x24 line buffer
// Ports:
//   clk, rst_n                   write-side clock, async active-low reset
//   i_frame_start, i_line_req    frame restart pulse, display line-advance (swap) pulse
//   o_req_valid/o_req_line/i_req_ready   line fetch request handshake to the pixel source
//   i_px_valid/i_px_data/o_px_ready      pixel stream from the source
//   o_wr_en/o_wr_addr/o_wr_data          registered line buffer write port, addr = {bank, x}
//   o_rd_bank                    half currently owned by the display read side
//   o_busy                       fetch or fill in progress
//   o_underrun, i_underrun_clr   sticky late-line flag and its clear (set wins)
module line_fill_ctrl
  import line_fill_ctrl_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int PIX_W    = PIX_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_frame_start,
  input  logic              i_line_req,
  output logic              o_req_valid,
  output logic [LINE_W-1:0] o_req_line,
  input  logic              i_req_ready,
  input  logic              i_px_valid,
  input  logic [PIX_W-1:0]  i_px_data,
  output logic              o_px_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [PIX_W-1:0]  o_wr_data,
  output logic              o_rd_bank,
  output logic              o_busy,
  output logic              o_underrun,
  input  logic              i_underrun_clr
);
  state_e              r_state, w_state_nxt;
  logic                r_fill_bank, r_rd_bank, r_filled, r_underrun, r_wr_en;
  logic [LINE_W-1:0]   r_fill_line, w_next_line;
  logic [X_W-1:0]      r_x;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [PIX_W-1:0]    r_wr_data;
  logic                w_beat, w_last, w_swap, w_miss;
  // frame_start overrides everything: no beat, no swap and no underrun in its cycle
  always_comb begin
    w_beat      = r_state == S_FILL && i_px_valid && !i_frame_start;
    w_last      = r_x == X_W'(H_ACTIVE - 1);
    w_swap      = i_line_req && r_filled && !i_frame_start;
    w_miss      = i_line_req && !r_filled && !i_frame_start;
    w_next_line = r_fill_line + 1'b1;
    w_state_nxt = i_frame_start                                                     ? S_REQ  :
                  (r_state == S_IDLE && w_swap && w_next_line < LINE_W'(V_ACTIVE)) ? S_REQ  :
                  (r_state == S_REQ && i_req_ready)                                 ? S_FILL :
                  (w_beat && w_last)                                                ? S_IDLE : r_state;
    o_req_valid = r_state == S_REQ;
    o_req_line  = r_fill_line;
    o_px_ready  = r_state == S_FILL && !i_frame_start;
    o_busy      = r_state != S_IDLE;
    o_wr_en     = r_wr_en;
    o_wr_addr   = r_wr_addr;
    o_wr_data   = r_wr_data;
    o_rd_bank   = r_rd_bank;
    o_underrun  = r_underrun;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_fill_bank <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_fill_line <= '0;
      r_x         <= '0;
      r_filled    <= 1'b0;
      r_underrun  <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_en    <= w_beat;
      r_underrun <= w_miss || (r_underrun && !i_underrun_clr);
      if (w_beat) begin
        r_wr_addr <= buf_addr(r_fill_bank, r_x);
        r_wr_data <= i_px_data;
        r_x       <= w_last ? '0 : r_x + 1'b1;
        if (w_last) r_filled <= 1'b1;
      end
      // a swap can only happen in IDLE, so it never overlaps a beat
      if (w_swap) begin
        r_rd_bank   <= r_fill_bank;
        r_fill_bank <= ~r_fill_bank;
        r_filled    <= 1'b0;
        r_fill_line <= w_next_line;
      end
      if (i_frame_start) begin
        r_fill_line <= '0;
        r_x         <= '0;
        r_filled    <= 1'b0;
        r_fill_bank <= ~r_rd_bank;
      end
    end
  end
endmodule

// File: tb/tb_line_fill_ctrl.sv
// tb_line_fill_ctrl: vector table, directed corner sequences and random run against a behavioural model
module tb_line_fill_ctrl;
  localparam int H = 8;
  localparam int V = 3;
  localparam int W = 24;
  logic clk = 0, rst_n = 0;
  logic fs = 0, lr = 0, rr = 0, pv = 0, clr = 0;
  logic [W-1:0] pd = '0;
  logic o_req_valid, o_px_ready, o_wr_en, o_rd_bank, o_busy, o_underrun;
  logic [9:0] o_req_line, o_wr_addr;
  logic [W-1:0] o_wr_data;
  int n_chk = 0, n_err = 0;

  line_fill_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .PIX_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .i_frame_start(fs), .i_line_req(lr),
    .o_req_valid(o_req_valid), .o_req_line(o_req_line), .i_req_ready(rr),
    .i_px_valid(pv), .i_px_data(pd), .o_px_ready(o_px_ready),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_rd_bank(o_rd_bank), .o_busy(o_busy), .o_underrun(o_underrun),
    .i_underrun_clr(clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic fs, lr, rr, pv, clr;
    logic [W-1:0] d;
    logic rv;
    logic [9:0] line;
    logic pr, we;
    logic [9:0] wa;
    logic busy, ur, rb;
  } vec_t;
  vec_t vq[$];

  function automatic vec_t mkv(input int f, l, r, p, c, d, rv, ln, pr, we, wa, b, u, rb);
    vec_t v;
    v.fs = f[0]; v.lr = l[0]; v.rr = r[0]; v.pv = p[0]; v.clr = c[0]; v.d = d[W-1:0];
    v.rv = rv[0]; v.line = ln[9:0]; v.pr = pr[0]; v.we = we[0]; v.wa = wa[9:0];
    v.busy = b[0]; v.ur = u[0]; v.rb = rb[0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic f, l, r, p, c, input logic [W-1:0] d);
    fs = f; lr = l; rr = r; pv = p; clr = c; pd = d;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // behavioural model state for the random run
  bit m_req, m_stream, m_done, m_fill, m_show, m_under, m_beat, m_set;
  int m_cnt, m_line;
  logic [9:0] e_wa;
  logic [W-1:0] e_wd;

  initial begin
    int writes;
    // reset values
    #2;
    chk("rst_req_valid", 32'(o_req_valid), 0);
    chk("rst_px_ready", 32'(o_px_ready), 0);
    chk("rst_wr_en", 32'(o_wr_en), 0);
    chk("rst_wr_addr", 32'(o_wr_addr), 0);
    chk("rst_wr_data", 32'(o_wr_data), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_underrun", 32'(o_underrun), 0);
    chk("rst_rd_bank", 32'(o_rd_bank), 0);
    @(negedge clk) rst_n = 1;
    tick;

    // frame 0 line 0 fills bank ~rd_bank = 1, swap, line 1 fills bank 0
    vq.push_back(mkv(1,0,0,0,0,0, 1,0,0,0,0,1,0,0));
    vq.push_back(mkv(0,0,1,0,0,0, 0,0,1,0,0,1,0,0));
    for (int k = 0; k < H; k++)
      vq.push_back(mkv(0,0,0,1,0,'hA00000+k, 0,0,int'(k<H-1),1,'h200+k,int'(k<H-1),0,0));
    vq.push_back(mkv(0,0,0,0,0,0, 0,0,0,0,'h207,0,0,0));
    vq.push_back(mkv(0,1,0,0,0,0, 1,1,0,0,'h207,1,0,1));
    vq.push_back(mkv(0,0,1,0,0,0, 0,1,1,0,'h207,1,0,1));
    for (int k = 0; k < H; k++)
      vq.push_back(mkv(0,0,0,1,0,'hB00000+k, 0,1,int'(k<H-1),1,k,int'(k<H-1),0,1));
    foreach (vq[i]) begin
      drive(vq[i].fs, vq[i].lr, vq[i].rr, vq[i].pv, vq[i].clr, vq[i].d);
      tick;
      chk($sformatf("vec%0d_req_valid", i), 32'(o_req_valid), 32'(vq[i].rv));
      chk($sformatf("vec%0d_req_line", i), 32'(o_req_line), 32'(vq[i].line));
      chk($sformatf("vec%0d_px_ready", i), 32'(o_px_ready), 32'(vq[i].pr));
      chk($sformatf("vec%0d_wr_en", i), 32'(o_wr_en), 32'(vq[i].we));
      chk($sformatf("vec%0d_wr_addr", i), 32'(o_wr_addr), 32'(vq[i].wa));
      if (vq[i].we) chk($sformatf("vec%0d_wr_data", i), 32'(o_wr_data), 32'(vq[i].d));
      chk($sformatf("vec%0d_busy", i), 32'(o_busy), 32'(vq[i].busy));
      chk($sformatf("vec%0d_underrun", i), 32'(o_underrun), 32'(vq[i].ur));
      chk($sformatf("vec%0d_rd_bank", i), 32'(o_rd_bank), 32'(vq[i].rb));
    end

    // underrun during fill of line 2
    drive(0,1,0,0,0,0); tick;
    chk("t3_swap_rd_bank", 32'(o_rd_bank), 0);
    chk("t3_req_line", 32'(o_req_line), 2);
    chk("t3_req_valid", 32'(o_req_valid), 1);
    drive(0,0,1,0,0,0); tick;
    for (int k = 0; k < 5; k++) begin
      drive(0,0,0,1,0,24'hC00000 + 24'(k)); tick;
      chk("t3_wa_pre", 32'(o_wr_addr), 32'h200 + 32'(k));
    end
    drive(0,1,0,0,0,0); tick;
    chk("t3_underrun_set", 32'(o_underrun), 1);
    chk("t3_rd_bank_kept", 32'(o_rd_bank), 0);
    chk("t3_no_write", 32'(o_wr_en), 0);
    chk("t3_busy", 32'(o_busy), 1);
    for (int k = 5; k < H; k++) begin
      drive(0,0,0,1,0,24'hC00000 + 24'(k)); tick;
      chk("t3_we_post", 32'(o_wr_en), 1);
      chk("t3_wa_post", 32'(o_wr_addr), 32'h200 + 32'(k));
    end
    chk("t3_busy_done", 32'(o_busy), 0);
    drive(0,0,0,0,1,0); tick;
    chk("t3_underrun_clr", 32'(o_underrun), 0);

    // third swap ends the frame, a fourth line_req is an underrun
    drive(0,1,0,0,0,0); tick;
    chk("t5_rd_bank", 32'(o_rd_bank), 1);
    chk("t5_no_req", 32'(o_req_valid), 0);
    chk("t5_busy", 32'(o_busy), 0);
    drive(0,0,0,0,0,0); tick; tick;
    chk("t5_still_no_req", 32'(o_req_valid), 0);
    drive(0,1,0,0,1,0); tick;
    chk("t5_set_wins", 32'(o_underrun), 1);
    chk("t5_no_swap", 32'(o_rd_bank), 1);
    drive(0,0,0,0,1,0); tick;
    chk("t5_clr", 32'(o_underrun), 0);

    // new frame fills bank ~rd_bank = 0 with a slow source
    drive(1,0,0,0,0,0); tick;
    chk("t4_req_valid", 32'(o_req_valid), 1);
    chk("t4_req_line", 32'(o_req_line), 0);
    drive(0,0,0,0,0,0);
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("t4_hold_valid", 32'(o_req_valid), 1);
      chk("t4_hold_line", 32'(o_req_line), 0);
    end
    drive(0,0,1,0,0,0); tick;
    chk("t4_accepted", 32'(o_req_valid), 0);
    writes = 0;
    for (int k = 0; k < 30 && writes < H; k++) begin
      drive(0,0,0,k % 2 == 0,0,24'hD00000 + 24'(k)); tick;
      chk("t4_we_only_on_beat", 32'(o_wr_en), 32'(k % 2 == 0));
      if (o_wr_en) begin
        chk("t4_wa", 32'(o_wr_addr), 32'(writes));
        writes++;
      end
    end
    chk("t4_write_count", 32'(writes), H);
    drive(0,0,0,0,0,0); tick;
    chk("t4_idle", 32'(o_busy), 0);

    // frame_start mid-fill together with line_req and a pixel
    drive(0,1,0,0,0,0); tick;
    chk("t6_swap", 32'(o_rd_bank), 0);
    drive(0,0,1,0,0,0); tick;
    for (int k = 0; k < 3; k++) begin
      drive(0,0,0,1,0,24'hE00000 + 24'(k)); tick;
      chk("t6_wa_pre", 32'(o_wr_addr), 32'h200 + 32'(k));
    end
    drive(1,1,0,1,0,24'hEEEEEE); #1;
    chk("t6_px_ready_gated", 32'(o_px_ready), 0);
    tick;
    chk("t6_no_write", 32'(o_wr_en), 0);
    chk("t6_no_swap", 32'(o_rd_bank), 0);
    chk("t6_req_valid", 32'(o_req_valid), 1);
    chk("t6_req_line", 32'(o_req_line), 0);
    chk("t6_no_underrun", 32'(o_underrun), 0);
    drive(0,0,1,0,0,0); tick;
    drive(0,0,0,1,0,24'hF00000); tick;
    chk("t6_x_restart", 32'(o_wr_addr), 32'h200);
    chk("t6_wd", 32'(o_wr_data), 32'hF00000);

    // asynchronous reset in the middle of a fill
    drive(0,1,0,0,0,0); tick;
    chk("t7_underrun_pre", 32'(o_underrun), 1);
    drive(0,0,0,1,0,24'hF00001); tick;
    chk("t7_we_pre", 32'(o_wr_en), 1);
    drive(0,0,0,0,0,0);
    @(negedge clk); rst_n = 0; #1;
    chk("t7_req_valid", 32'(o_req_valid), 0);
    chk("t7_px_ready", 32'(o_px_ready), 0);
    chk("t7_wr_en", 32'(o_wr_en), 0);
    chk("t7_wr_addr", 32'(o_wr_addr), 0);
    chk("t7_wr_data", 32'(o_wr_data), 0);
    chk("t7_busy", 32'(o_busy), 0);
    chk("t7_underrun", 32'(o_underrun), 0);
    chk("t7_rd_bank", 32'(o_rd_bank), 0);
    chk("t7_req_line", 32'(o_req_line), 0);
    @(negedge clk) rst_n = 1;
    tick;

    // random traffic against the model
    m_req = 0; m_stream = 0; m_done = 0; m_fill = 0; m_show = 0; m_under = 0;
    m_cnt = 0; m_line = 0; e_wa = '0; e_wd = '0;
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0,59) == 0, $urandom_range(0,11) == 0, $urandom_range(0,1) == 1,
            $urandom_range(0,3) != 0, $urandom_range(0,15) == 0, 24'($urandom));
      #1;
      chk("rnd_req_valid", 32'(o_req_valid), 32'(m_req));
      if (m_req) chk("rnd_req_line", 32'(o_req_line), 32'(m_line));
      chk("rnd_px_ready", 32'(o_px_ready), 32'(m_stream && !fs));
      chk("rnd_busy", 32'(o_busy), 32'(m_req || m_stream));
      chk("rnd_underrun", 32'(o_underrun), 32'(m_under));
      chk("rnd_rd_bank", 32'(o_rd_bank), 32'(m_show));
      m_beat = m_stream && pv && !fs;
      m_set = lr && !m_done && !fs;
      if (fs) begin
        m_line = 0; m_cnt = 0; m_done = 0; m_fill = !m_show; m_req = 1; m_stream = 0;
      end else begin
        if (m_beat) begin
          e_wa = {m_fill, 9'(m_cnt)};
          e_wd = pd;
          m_cnt++;
          if (m_cnt == H) begin m_cnt = 0; m_stream = 0; m_done = 1; end
        end
        if (m_req && rr) begin m_req = 0; m_stream = 1; end
        if (lr && !m_set) begin
          m_show = m_fill; m_fill = !m_fill; m_done = 0; m_line++; m_req = m_line < V;
        end
      end
      m_under = m_set ? 1'b1 : (clr ? 1'b0 : m_under);
      @(posedge clk); #1;
      chk("rnd_wr_en", 32'(o_wr_en), 32'(m_beat));
      chk("rnd_wr_addr", 32'(o_wr_addr), 32'(e_wa));
      chk("rnd_wr_data", 32'(o_wr_data), 32'(e_wd));
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
